ir_cam_ctrl: RTL and testbench
==============================

IR_CAM_CTRL -- requirements
Module: ir_cam_ctrl

Interface
REQ-001 Parameter CAM_ADDR, default 7'h58, 7-bit I2C address of the IR camera.
REQ-002 Parameter GAP_CYCLES, default 4, idle clk cycles enforced between consecutive transactions (minimum 2).
REQ-003 Parameter POLL_CYCLES, default 1000, clk cycles from one blob capture to the next poll start.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enable  in  1  high = run init then continuous polling.
REQ-007 i2c_ready  in  1  master ready (high in master idle/stop).
REQ-008 i2c_data_out  in  128  master read data, first received byte in [127:120].
REQ-009 i2c_start  out  1  transaction request to master.
REQ-010 i2c_rw  out  1  1 = read, 0 = write.
REQ-011 i2c_addr  out  7  always CAM_ADDR.
REQ-012 i2c_data  out  128  write payload, first byte sent at [(packets-1)*8+7 : (packets-1)*8].
REQ-013 i2c_packets  out  5  byte count of the transaction.
REQ-014 init_done  out  1  init sequence complete.
REQ-015 blob_x, blob_y  out  10 each  blob-1 coordinates.
REQ-016 blob_valid  out  1  blob-1 present in last capture.
REQ-017 blob_strobe  out  1  one-cycle pulse on each capture.

Function
REQ-018 Step index 0..7: steps 0-5 two-byte writes (reg,val) = (30,01),(30,08),(06,90),(08,C0),(1A,40),(33,33) hex; step 6 one-byte write 36h; step 7 sixteen-byte read.
REQ-019 Two-byte write: packets=2, i2c_data[15:8]=reg, [7:0]=val, other bits 0, rw=0.
REQ-020 Pointer write: packets=1, i2c_data[7:0]=36h, other bits 0, rw=0; read: packets=16, i2c_data=0, rw=1.
REQ-021 States: IDLE, ISSUE, WAIT_DONE, GAP, CAPTURE, POLL_WAIT.
REQ-022 IDLE: when enable=1 and i2c_ready=1 -> ISSUE with step = init_done ? 6 : 0.
REQ-023 ISSUE: i2c_start=1 with stable rw/data/packets; hold until i2c_ready=0, then -> WAIT_DONE with start=0 that same edge.
REQ-024 WAIT_DONE: on i2c_ready=1 -> CAPTURE if step=7, else GAP.
REQ-025 GAP: count GAP_CYCLES, then: step 5 sets init_done=1; if enable=0 -> IDLE; else step+1 and -> ISSUE.
REQ-026 CAPTURE (1 cycle): byte1=[119:112], byte2=[111:104], byte3=[103:96]; blob_x={byte3[5:4],byte1}, blob_y={byte3[7:6],byte2}; blob_valid = not(byte1=FF and byte2=FF and byte3=FF); blob_strobe=1; -> POLL_WAIT.
REQ-027 POLL_WAIT: count POLL_CYCLES; then enable=0 -> IDLE, else step=6 -> ISSUE.
REQ-028 Outputs i2c_rw/data/packets are held constant from ISSUE entry until WAIT_DONE exit.
REQ-029 enable dropping mid-transaction shall not abort it; the current transaction completes and the block returns to IDLE at the next GAP/POLL_WAIT exit.
REQ-030 blob_x/blob_y/blob_valid hold until next CAPTURE.
REQ-031 Counters sized for parameter values; no wrap before terminal count.

Reset
REQ-032 reset=1: state IDLE, step 0, counters 0, i2c_start=0, i2c_rw=0, i2c_data=0, i2c_packets=0, init_done=0, blob_x=0, blob_y=0, blob_valid=0, blob_strobe=0; i2c_addr=CAM_ADDR.
REQ-033 reset mid-transaction takes effect next edge regardless of i2c_ready; master is reset by the same signal.

Structure
REQ-034 Package ir_cam_pkg: state enum, CAM_ADDR default, init (reg,val) table, pointer byte 36h, read length 16.
REQ-035 One sub-module ir_cam_init_rom: combinational step(3b) -> {rw, packets, data[15:0]}.

Verification (bench with behavioural master model, ready low 20 cycles per transaction)
REQ-036 Reset, enable=1 -> six writes with i2c_data[15:0]=3001h,3008h,0690h,08C0h,1A40h,3333h, packets=2, each separated by >=GAP_CYCLES; init_done after sixth.
REQ-037 After init -> write 36h packets=1, then read packets=16 rw=1; repeats every POLL_CYCLES.
REQ-038 Read data bytes1..3 = 64h,C8h,90h -> blob_x=164h, blob_y=2C8h, blob_valid=1, one-cycle blob_strobe.
REQ-039 Read bytes1..3 = FFh,FFh,FFh -> blob_valid=0, strobe still pulses.
REQ-040 enable=0 during step 3 -> step 3 completes, IDLE, no step 4; re-enable -> resumes at step 0 (init_done=0).
REQ-041 reset asserted while i2c_start=1 -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/ir_cam_pkg.sv
// ir_cam_pkg: shared definitions for the IR camera controller.
//   state_e          - controller FSM states
//   CAM_ADDR_DEFAULT - default 7-bit I2C address of the camera
//   INIT_TABLE       - (reg,val) pairs written during init, index 0 first
//   PTR_BYTE         - register pointer written before each blob read
//   READ_LEN         - byte count of the blob read
package ir_cam_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_CAPTURE,
    S_POLL_WAIT
  } state_e;

  localparam logic [6:0] CAM_ADDR_DEFAULT = 7'h58;

  localparam int unsigned INIT_STEPS = 6;

  // Packed so that element 0 is the first write of the init sequence.
  localparam logic [INIT_STEPS-1:0][15:0] INIT_TABLE = {
    16'h3333, 16'h1A40, 16'h08C0, 16'h0690, 16'h3008, 16'h3001
  };

  localparam logic [2:0] LAST_INIT_STEP = 3'd5;
  localparam logic [2:0] PTR_STEP       = 3'd6;
  localparam logic [2:0] READ_STEP      = 3'd7;

  localparam logic [7:0] PTR_BYTE  = 8'h36;
  localparam logic [4:0] WRITE_LEN = 5'd2;
  localparam logic [4:0] PTR_LEN   = 5'd1;
  localparam logic [4:0] READ_LEN  = 5'd16;

endpackage

// File: rtl/ir_cam_init_rom.sv
// ir_cam_init_rom: maps a sequence step to the I2C transaction it issues.
//   step    in  3   0-5 init register writes, 6 pointer write, 7 blob read
//   rw      out 1   1 = read
//   packets out 5   byte count
//   data    out 16  write payload (first byte in the upper half for 2-byte writes)
module ir_cam_init_rom
  import ir_cam_pkg::*;
(
  input  logic [2:0]  step,
  output logic        rw,
  output logic [4:0]  packets,
  output logic [15:0] data
);

  always_comb begin
    rw      = 1'b0;
    packets = '0;
    data    = '0;
    if (step == READ_STEP) begin
      rw      = 1'b1;
      packets = READ_LEN;
    end else if (step == PTR_STEP) begin
      packets = PTR_LEN;
      data    = {8'h00, PTR_BYTE};
    end else begin
      packets = WRITE_LEN;
      data    = INIT_TABLE[step];
    end
  end

endmodule

// File: rtl/ir_cam_ctrl.sv
// ir_cam_ctrl: drives an I2C master to initialise an IR camera and then
// poll it continuously, decoding the coordinates of blob 1.
//   clk, reset           clock, synchronous active-high reset
//   enable               run init, then continuous polling
//   i2c_ready            master idle
//   i2c_data_out[127:0]  read data, first byte in [127:120]
//   i2c_start/rw/addr/data/packets  transaction request to the master
//   init_done            init sequence has completed
//   blob_x/blob_y/blob_valid  blob-1 result of the last capture
//   blob_strobe          one-cycle pulse per capture
module ir_cam_ctrl
  import ir_cam_pkg::*;
#(
  parameter logic [6:0]  CAM_ADDR    = CAM_ADDR_DEFAULT,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned POLL_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         i2c_ready,
  input  logic [127:0] i2c_data_out,
  output logic         i2c_start,
  output logic         i2c_rw,
  output logic [6:0]   i2c_addr,
  output logic [127:0] i2c_data,
  output logic [4:0]   i2c_packets,
  output logic         init_done,
  output logic [9:0]   blob_x,
  output logic [9:0]   blob_y,
  output logic         blob_valid,
  output logic         blob_strobe
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > POLL_CYCLES) ? GAP_CYCLES : POLL_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_END = CNT_W'(POLL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               rw_q, rw_d;
  logic [127:0]       data_q, data_d;
  logic [4:0]         packets_q, packets_d;
  logic               init_done_q, init_done_d;
  logic [9:0]         blob_x_q, blob_x_d;
  logic [9:0]         blob_y_q, blob_y_d;
  logic               blob_valid_q, blob_valid_d;
  logic               blob_strobe_q, blob_strobe_d;
  logic               load;

  logic               rom_rw;
  logic [4:0]         rom_packets;
  logic [15:0]        rom_data;

  logic [7:0]         rd_b1, rd_b2, rd_b3;
  logic               unused_rd_bits;

  assign rd_b1 = i2c_data_out[119:112];
  assign rd_b2 = i2c_data_out[111:104];
  assign rd_b3 = i2c_data_out[103:96];
  // Only blob 1 is decoded; the header byte and later blobs are ignored.
  assign unused_rd_bits = ^{i2c_data_out[127:120], i2c_data_out[95:0]};

  // ROM looks at the step being entered so the payload is registered
  // together with i2c_start on ISSUE entry.
  ir_cam_init_rom u_rom (
    .step    (step_d),
    .rw      (rom_rw),
    .packets (rom_packets),
    .data    (rom_data)
  );

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    start_d       = start_q;
    init_done_d   = init_done_q;
    blob_x_d      = blob_x_q;
    blob_y_d      = blob_y_q;
    blob_valid_d  = blob_valid_q;
    blob_strobe_d = 1'b0;
    load          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && i2c_ready) begin
          step_d  = init_done_q ? PTR_STEP : 3'd0;
          state_d = S_ISSUE;
          start_d = 1'b1;
          load    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!i2c_ready) begin
          start_d = 1'b0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i2c_ready) begin
          cnt_d   = '0;
          state_d = (step_q == READ_STEP) ? S_CAPTURE : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (step_q == LAST_INIT_STEP) init_done_d = 1'b1;
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_ISSUE;
            start_d = 1'b1;
            load    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        blob_x_d      = {rd_b3[5:4], rd_b1};
        blob_y_d      = {rd_b3[7:6], rd_b2};
        blob_valid_d  = !((rd_b1 == 8'hFF) && (rd_b2 == 8'hFF) && (rd_b3 == 8'hFF));
        blob_strobe_d = 1'b1;
        cnt_d         = '0;
        state_d       = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (cnt_q == POLL_END) begin
          cnt_d = '0;
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            step_d  = PTR_STEP;
            state_d = S_ISSUE;
            start_d = 1'b1;
            load    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Kept apart from the FSM block: the ROM input depends on step_d, so
  // merging would form a false combinational loop through the ROM.
  always_comb begin
    rw_d      = rw_q;
    packets_d = packets_q;
    data_d    = data_q;
    if (load) begin
      rw_d      = rom_rw;
      packets_d = rom_packets;
      data_d    = {{112{1'b0}}, rom_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      rw_q          <= 1'b0;
      data_q        <= '0;
      packets_q     <= '0;
      init_done_q   <= 1'b0;
      blob_x_q      <= '0;
      blob_y_q      <= '0;
      blob_valid_q  <= 1'b0;
      blob_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      rw_q          <= rw_d;
      data_q        <= data_d;
      packets_q     <= packets_d;
      init_done_q   <= init_done_d;
      blob_x_q      <= blob_x_d;
      blob_y_q      <= blob_y_d;
      blob_valid_q  <= blob_valid_d;
      blob_strobe_q <= blob_strobe_d;
    end
  end

  assign i2c_start   = start_q;
  assign i2c_rw      = rw_q;
  assign i2c_addr    = CAM_ADDR;
  assign i2c_data    = data_q;
  assign i2c_packets = packets_q;
  assign init_done   = init_done_q;
  assign blob_x      = blob_x_q;
  assign blob_y      = blob_y_q;
  assign blob_valid  = blob_valid_q;
  assign blob_strobe = blob_strobe_q;

endmodule

// File: tb/tb_ir_cam_ctrl.sv
// tb_ir_cam_ctrl: self-checking bench for ir_cam_ctrl with a behavioural
// I2C master (ready low for 20 cycles per transaction). Expected
// transactions, read payloads and blob results are queued up front and
// consumed as the DUT produces them.
module tb_ir_cam_ctrl;

  localparam int unsigned GAP_CYCLES  = 4;
  localparam int unsigned POLL_CYCLES = 50;
  localparam int unsigned BUSY_CYCLES = 20;

  typedef struct {
    logic [7:0] b1, b2, b3;
    logic [9:0] ex, ey;
    logic       ev;
  } vec_t;

  typedef struct {
    logic       rw;
    logic [4:0] pk;
    logic [15:0] d;
  } txn_t;

  typedef struct {
    logic [9:0] x, y;
    logic       v;
  } blob_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         i2c_ready;
  logic [127:0] i2c_data_out;
  logic         i2c_start;
  logic         i2c_rw;
  logic [6:0]   i2c_addr;
  logic [127:0] i2c_data;
  logic [4:0]   i2c_packets;
  logic         init_done;
  logic [9:0]   blob_x, blob_y;
  logic         blob_valid, blob_strobe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ntxn = 0;
  int nstrobe = 0;
  int strobe_cyc = 0;
  logic busy = 1'b0;

  txn_t         txn_q[$];
  logic [127:0] rd_q[$];
  blob_t        blob_q[$];
  vec_t         vecs[6];
  logic [15:0]  init_exp[6];

  ir_cam_ctrl #(
    .GAP_CYCLES  (GAP_CYCLES),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .i2c_ready    (i2c_ready),
    .i2c_data_out (i2c_data_out),
    .i2c_start    (i2c_start),
    .i2c_rw       (i2c_rw),
    .i2c_addr     (i2c_addr),
    .i2c_data     (i2c_data),
    .i2c_packets  (i2c_packets),
    .init_done    (init_done),
    .blob_x       (blob_x),
    .blob_y       (blob_y),
    .blob_valid   (blob_valid),
    .blob_strobe  (blob_strobe)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start"},      i2c_start,   1'b0);
    chk({tag, "_rw"},         i2c_rw,      1'b0);
    chk({tag, "_data"},       i2c_data,    128'h0);
    chk({tag, "_packets"},    i2c_packets, 5'd0);
    chk({tag, "_init_done"},  init_done,   1'b0);
    chk({tag, "_blob_x"},     blob_x,      10'd0);
    chk({tag, "_blob_y"},     blob_y,      10'd0);
    chk({tag, "_blob_valid"}, blob_valid,  1'b0);
    chk({tag, "_strobe"},     blob_strobe, 1'b0);
    chk({tag, "_addr"},       i2c_addr,    7'h58);
  endtask

  task automatic push_init(input int n);
    for (int i = 0; i < n; i++) txn_q.push_back('{1'b0, 5'd2, init_exp[i]});
  endtask

  task automatic push_poll(input vec_t v);
    logic [127:0] p;
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    p[119:96] = {v.b1, v.b2, v.b3};
    txn_q.push_back('{1'b0, 5'd1, 16'h0036});
    txn_q.push_back('{1'b1, 5'd16, 16'h0000});
    rd_q.push_back(p);
    blob_q.push_back('{v.ex, v.ey, v.ev});
  endtask

  // Behavioural I2C master: accepts a start while idle, holds ready low
  // for BUSY_CYCLES, checks the request against the scoreboard.
  initial begin : master
    txn_t t;
    logic cur_rw;
    logic [4:0] cur_pk;
    logic [127:0] cur_data;
    int busy_left;
    int rise_cyc;
    logic have_rise;
    logic last_was_read;
    have_rise = 1'b0;
    last_was_read = 1'b0;
    busy_left = 0;
    rise_cyc = 0;
    i2c_ready = 1'b1;
    i2c_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        i2c_ready = 1'b1;
        busy = 1'b0;
      end else if (busy) begin
        busy_left--;
        if (busy_left == 0) begin
          chk("hold_data", i2c_data, cur_data);
          chk("hold_ctl", {i2c_rw, i2c_packets}, {cur_rw, cur_pk});
          i2c_ready = 1'b1;
          busy = 1'b0;
          rise_cyc = cyc;
          have_rise = 1'b1;
          last_was_read = cur_rw;
        end
      end else if (i2c_start) begin
        ntxn++;
        if (have_rise) begin
          checks++;
          if (cyc - rise_cyc < int'(GAP_CYCLES)) begin
            errors++;
            $display("FAIL txn_gap: got %0d idle cycles, required >= %0d", cyc - rise_cyc, GAP_CYCLES);
          end
        end
        if (txn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got rw=%0d packets=%0d, expected no transaction", i2c_rw, i2c_packets);
        end else begin
          t = txn_q.pop_front();
          chk("txn_rw", i2c_rw, t.rw);
          chk("txn_packets", i2c_packets, t.pk);
          chk("txn_data", i2c_data, {112'h0, t.d});
          chk("txn_init_done", init_done, t.pk != 5'd2);
          if (t.pk == 5'd1 && last_was_read)
            chk("poll_period", cyc - strobe_cyc, POLL_CYCLES);
        end
        chk("txn_addr", i2c_addr, 7'h58);
        cur_rw = i2c_rw;
        cur_pk = i2c_packets;
        cur_data = i2c_data;
        if (i2c_rw) begin
          if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_payload: got read request, expected none queued");
          end else begin
            i2c_data_out = rd_q.pop_front();
          end
        end
        i2c_ready = 1'b0;
        busy = 1'b1;
        busy_left = BUSY_CYCLES;
      end
    end
  end

  initial begin : blob_mon
    blob_t b;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) begin
        chk("strobe_pulse", blob_strobe, 1'b0);
      end else if (blob_strobe) begin
        nstrobe++;
        strobe_cyc = cyc;
        if (blob_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe, expected none");
        end else begin
          b = blob_q.pop_front();
          chk("blob_x", blob_x, b.x);
          chk("blob_y", blob_y, b.y);
          chk("blob_valid", blob_valid, b.v);
        end
      end
      prev = blob_strobe;
    end
  end

  initial begin : main
    int base;
    init_exp = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3333};
    vecs[0] = '{8'h64, 8'hC8, 8'h90, 10'h164, 10'h2C8, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 10'h3FF, 10'h3FF, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 10'h000, 10'h000, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 10'h3FF, 10'h3FF, 1'b1};
    vecs[4] = '{8'h12, 8'h34, 8'h30, 10'h312, 10'h034, 1'b1};
    vecs[5] = '{8'hAB, 8'hCD, 8'hC0, 10'h0AB, 10'h3CD, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    reset = 1'b0;

    // Full init followed by one poll per table vector.
    push_init(6);
    foreach (vecs[i]) push_poll(vecs[i]);
    enable = 1'b1;
    for (int i = 0; i < 4000 && nstrobe < 6; i++) @(negedge clk);
    chk("phase1_strobes", nstrobe, 6);
    enable = 1'b0;
    repeat (120) @(negedge clk);
    chk("phase1_txn_left", txn_q.size(), 0);
    chk("phase1_init_done", init_done, 1'b1);
    chk("phase1_idle_start", i2c_start, 1'b0);
    chk("hold_blob", {blob_x, blob_y, blob_valid}, {vecs[5].ex, vecs[5].ey, vecs[5].ev});

    // Enable dropped while step 3 is in flight.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("phase2_init_done_rst", init_done, 1'b0);
    base = ntxn;
    push_init(4);
    enable = 1'b1;
    for (int i = 0; i < 1000 && ntxn < base + 4; i++) @(negedge clk);
    chk("phase2_step3_seen", ntxn, base + 4);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    chk("phase2_txn_count", ntxn, base + 4);
    chk("phase2_txn_left", txn_q.size(), 0);
    chk("phase2_master_idle", busy, 1'b0);
    chk("phase2_init_done", init_done, 1'b0);

    // Re-enable restarts init from step 0.
    push_init(6);
    push_poll(vecs[0]);
    enable = 1'b1;
    for (int i = 0; i < 2000 && nstrobe < 7; i++) @(negedge clk);
    chk("phase3_strobes", nstrobe, 7);
    chk("phase3_init_done", init_done, 1'b1);

    // Reset landing while i2c_start is high.
    txn_q.push_back('{1'b0, 5'd1, 16'h0036});
    for (int i = 0; i < 200 && !i2c_start; i++) @(negedge clk);
    chk("phase4_start_seen", i2c_start, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check_reset("midreset");
    enable = 1'b0;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("final_txn_left", txn_q.size(), 0);
    chk("final_rd_left", rd_q.size(), 0);
    chk("final_blob_left", blob_q.size(), 0);
    chk("final_idle_start", i2c_start, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
